mul_issue_stage: RTL and testbench

MUL_ISSUE_STAGE -- requirements
Module: mul_issue_stage

---
 rtl/mul_issue_stage.sv | 153 +++++++++++++++
 tb/tb_mul_issue_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_issue_stage.sv
// mul_issue_stage
//   Issue stage for an external combinational 32x32 multiplier. Operands are
//   registered onto mul_a/mul_b and given MUL_CYCLES clocks to settle. The
//   product is then loaded into, or added to, a 64-bit accumulator. Each
//   result is queued in a FIFO_DEPTH-entry result FIFO.
//   A FIFO slot is reserved when a request is accepted, so a push never
//   finds the FIFO full.
//
//   Optional feature: define MUL_ISSUE_ACC_SAT_EN to make accumulation
//   saturate. A carry-out clamps the result to all-ones and sets out_sat.
//   Without the macro, accumulation wraps and out_sat is tied to 0.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     operand request handshake
//   in_a, in_b, in_acc    operands; in_acc=1 accumulates, 0 loads
//   mul_a, mul_b, mul_p   external multiplier operands / product
//   out_valid/out_ready   result FIFO head handshake
//   out_data, out_sat     head result and its saturation flag
//   busy                  high while a multiply is in flight
module mul_issue_stage #(
    parameter int MUL_CYCLES = 1,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_acc,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_p,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        out_sat,
    output logic        busy
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t          state, state_nxt;
    logic [2:0]      cnt;
    logic            acc_mode;
    logic [63:0]     acc;
    logic [PW-1:0]   wptr, rptr;
    logic [CW-1:0]   fifo_count;
    logic [63:0]     data_mem [FIFO_DEPTH];
    logic            hs, push, pop;
    logic [63:0]     result;
    logic            res_sat;

    assign hs   = in_valid && in_ready;
    assign push = (state == MUL) && (cnt == 3'd0);
    assign pop  = out_valid && out_ready;

    // Result computation from the settled product
`ifdef MUL_ISSUE_ACC_SAT_EN
    logic [64:0] sum;
    logic        sat_mem [FIFO_DEPTH];
    always_comb begin
        sum     = {1'b0, acc} + {1'b0, mul_p};
        res_sat = acc_mode && sum[64];
        result  = mul_p;
        if (acc_mode)
            result = sum[64] ? {64{1'b1}} : sum[63:0];
    end
`else
    always_comb begin
        res_sat = 1'b0;
        result  = acc_mode ? (acc + mul_p) : mul_p;
    end
`endif

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hs)   state_nxt = MUL;
            MUL:     if (push) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy      = (state == MUL);
        in_ready  = (state == IDLE) && (fifo_count < CW'(FIFO_DEPTH));
        out_valid = (fifo_count != '0);
        // Drive zeros when empty so idle outputs are deterministic
        out_data  = out_valid ? data_mem[rptr] : 64'd0;
`ifdef MUL_ISSUE_ACC_SAT_EN
        out_sat   = out_valid ? sat_mem[rptr] : 1'b0;
`else
        out_sat   = 1'b0;
`endif
    end

    // Datapath, counter and FIFO control
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= 3'd0;
            acc        <= 64'd0;
            acc_mode   <= 1'b0;
            mul_a      <= 32'd0;
            mul_b      <= 32'd0;
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
        end else begin
            if (hs) begin
                mul_a    <= in_a;
                mul_b    <= in_b;
                acc_mode <= in_acc;
                cnt      <= 3'(MUL_CYCLES - 1);
            end else if ((state == MUL) && (cnt != 3'd0)) begin
                cnt <= cnt - 3'd1;
            end
            if (push) begin
                acc  <= result;
                wptr <= (wptr == PW'(FIFO_DEPTH - 1)) ? '0 : wptr + PW'(1);
            end
            if (pop)
                rptr <= (rptr == PW'(FIFO_DEPTH - 1)) ? '0 : rptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            data_mem[wptr] <= result;
`ifdef MUL_ISSUE_ACC_SAT_EN
            sat_mem[wptr]  <= res_sat;
`endif
        end
    end

endmodule

// File: tb/tb_mul_issue_stage.sv
// Scoreboard bench for mul_issue_stage. The main instance uses MUL_CYCLES=1.
// A second instance uses MUL_CYCLES=4 for the reset-abort case. Expected
// results are queued at each handshake, and a monitor per instance pops them
// when a result is taken.
module tb_mul_issue_stage;
    logic        clk = 0;
    always #5 clk = ~clk;

    typedef struct packed {logic [63:0] data; logic sat;} exp_t;

    int checks = 0;
    int errors = 0;

`ifdef MUL_ISSUE_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    // ---------------- main instance (MUL_CYCLES=1) ----------------
    logic        rst_n, in_valid, in_ready, in_acc, out_valid, out_ready, out_sat, busy;
    logic [31:0] in_a, in_b, mul_a, mul_b;
    logic [63:0] mul_p, out_data;
    assign mul_p = 64'(mul_a) * 64'(mul_b);

    mul_issue_stage #(.MUL_CYCLES(1), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_acc(in_acc), .mul_a(mul_a), .mul_b(mul_b),
        .mul_p(mul_p), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat), .busy(busy)
    );

    // ---------------- second instance (MUL_CYCLES=4) ----------------
    logic        rst4_n, in_valid4, in_ready4, in_acc4, out_valid4, out_ready4, out_sat4, busy4;
    logic [31:0] in_a4, in_b4, mul_a4, mul_b4;
    logic [63:0] mul_p4, out_data4;
    assign mul_p4 = 64'(mul_a4) * 64'(mul_b4);

    mul_issue_stage #(.MUL_CYCLES(4), .FIFO_DEPTH(2)) dut4 (
        .clk(clk), .rst_n(rst4_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_a(in_a4), .in_b(in_b4), .in_acc(in_acc4), .mul_a(mul_a4), .mul_b(mul_b4),
        .mul_p(mul_p4), .out_valid(out_valid4), .out_ready(out_ready4),
        .out_data(out_data4), .out_sat(out_sat4), .busy(busy4)
    );

    exp_t exp_q[$];
    exp_t exp4_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor, main instance: scoreboard pop plus hold-while-stalled check
    logic        stall_q = 0;
    logic [63:0] stall_data;
    logic        stall_sat;
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_q && out_valid) begin
                chk("hold_data", out_data, stall_data);
                chk("hold_sat", 64'(out_sat), 64'(stall_sat));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 64'(out_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_sat", 64'(out_sat), 64'(e.sat));
                end
            end
            stall_q    <= out_valid && !out_ready;
            stall_data <= out_data;
            stall_sat  <= out_sat;
        end else begin
            stall_q <= 1'b0;
        end
    end

    // Monitor, MUL_CYCLES=4 instance
    always @(negedge clk) begin
        if (rst4_n && out_valid4 && out_ready4) begin
            if (exp4_q.size() == 0) begin
                chk("unexpected_out4", 64'(out_valid4), 64'd0);
            end else begin
                exp_t e;
                e = exp4_q.pop_front();
                chk("out_data4", out_data4, e.data);
                chk("out_sat4", 64'(out_sat4), 64'(e.sat));
            end
        end
    end

    // Issue one request on the main instance. Returns 1 time unit after
    // the handshake edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic acc,
                        input logic [63:0] ed, input logic es);
        int n = 0;
        in_valid = 1; in_a = a; in_b = b; in_acc = acc;
        while (!in_ready) begin
            @(posedge clk); #1;
            n++;
            if (n > 200) begin
                chk("in_ready_timeout", 64'(in_ready), 64'd1);
                break;
            end
        end
        @(posedge clk);
        exp_q.push_back('{data: ed, sat: es});
        #1 in_valid = 0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0; in_valid = 0; in_a = 0; in_b = 0; in_acc = 0; out_ready = 1;
        rst4_n = 0; in_valid4 = 0; in_a4 = 0; in_b4 = 0; in_acc4 = 0; out_ready4 = 1;
        cyc(3);
        rst_n = 1; rst4_n = 1;
        cyc(1);

        // Reset state
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_sat", 64'(out_sat), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mul_a", 64'(mul_a), 64'd0);

        // Max operands: result appears in the 2nd cycle after the handshake
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 64'hFFFFFFFE00000001, 0);
        chk("busy_in_mul", 64'(busy), 64'd1);
        chk("lat_cycle1", 64'(out_valid), 64'd0);
        cyc(1);
        chk("lat_cycle2", 64'(out_valid), 64'd1);

        // Load then accumulate, back-to-back
        send(3, 5, 0, 64'd15, 0);
        send(7, 11, 1, 64'd92, 0);

        // Accumulator overflow: wraps, or saturates when the feature is built in
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 64'hFFFFFFFE00000001, 0);
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 1,
             SAT ? 64'hFFFFFFFFFFFFFFFF : 64'hFFFFFFFC00000002, SAT);
        cyc(4);

        // Backpressure: two results fill the FIFO, third request must wait
        out_ready = 0;
        send(2, 3, 0, 64'd6, 0);
        send(4, 5, 1, 64'd26, 0);
        cyc(3);
        in_valid = 1; in_a = 6; in_b = 7; in_acc = 1;
        for (int i = 0; i < 3; i++) begin
            chk("full_in_ready", 64'(in_ready), 64'd0);
            chk("full_out_valid", 64'(out_valid), 64'd1);
            cyc(1);
        end
        out_ready = 1;
        send(6, 7, 1, 64'd68, 0);
        cyc(4);

        // Simultaneous push and pop, then a stream that wraps the pointers
        out_ready = 0;
        send(1, 1, 0, 64'd1, 0);
        cyc(3);
        send(2, 2, 1, 64'd5, 0);
        out_ready = 1;
        cyc(1);
        chk("pushpop_count", 64'(dut.fifo_count), 64'd1);
        chk("pushpop_valid", 64'(out_valid), 64'd1);
        chk("pushpop_in_ready", 64'(in_ready), 64'd1);
        send(3, 3, 1, 64'd14, 0);
        send(4, 4, 1, 64'd30, 0);
        send(5, 5, 1, 64'd55, 0);
        cyc(4);
        chk("mul_a_held", 64'(mul_a), 64'd5);
        chk("mul_b_held", 64'(mul_b), 64'd5);

        // MUL_CYCLES=4: complete one op so acc is nonzero
        in_valid4 = 1; in_a4 = 10; in_b4 = 10; in_acc4 = 0;
        @(posedge clk);
        exp4_q.push_back('{data: 64'd100, sat: 1'b0});
        #1 in_valid4 = 0;
        cyc(8);
        // Abort an op by resetting in its 2nd MUL cycle
        in_valid4 = 1; in_a4 = 9; in_b4 = 9; in_acc4 = 1;
        @(posedge clk); #1 in_valid4 = 0;
        chk("r4_busy", 64'(busy4), 64'd1);
        cyc(1);
        rst4_n = 0;
        cyc(1);
        rst4_n = 1;
        chk("r4_busy_rel", 64'(busy4), 64'd0);
        chk("r4_in_ready_rel", 64'(in_ready4), 64'd1);
        chk("r4_out_valid_rel", 64'(out_valid4), 64'd0);
        chk("r4_out_data_rel", out_data4, 64'd0);
        for (int i = 0; i < 6; i++) begin
            chk("r4_no_valid", 64'(out_valid4), 64'd0);
            cyc(1);
        end
        // acc must be 0 again: 0 + 5*6 = 30, valid 5 cycles after handshake
        in_valid4 = 1; in_a4 = 5; in_b4 = 6; in_acc4 = 1;
        @(posedge clk);
        exp4_q.push_back('{data: 64'd30, sat: 1'b0});
        #1 in_valid4 = 0;
        for (int i = 0; i < 3; i++) begin
            chk("r4_lat_low", 64'(out_valid4), 64'd0);
            cyc(1);
        end
        chk("r4_lat_low", 64'(out_valid4), 64'd0);
        cyc(1);
        chk("r4_lat_high", 64'(out_valid4), 64'd1);

        // Drain, bounded
        for (int i = 0; i < 50 && (exp_q.size() != 0 || exp4_q.size() != 0); i++) cyc(1);
        chk("drain_main", 64'(exp_q.size()), 64'd0);
        chk("drain_4", 64'(exp4_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
